uart_tx: RTL and testbench
==========================

# uart_tx

UART transmitter with a small input FIFO: it serialises bytes as 8N1 frames, or 8N2 when `STOP_BITS=2`, on the `tx` line. The frame is LSB first, with an idle-high line, a start bit of 0 and a stop bit of 1. Bit timing comes from a 1x `baud_tick` supplied by the shared baud generator. It is the transmit-side counterpart of the UART receiver, and a `tx` to receiver `rx` loopback must deliver every byte intact.

## Interface
- `FIFO_DEPTH`, default 4: number of queued bytes; power of two, ≥2.
- `STOP_BITS`, default 1: stop bits per frame; legal values 1 or 2.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `baud_tick` in 1: one-`clk` pulse per bit period; pulses are ≥2 `clk` apart.
- `wr_en` in 1: write strobe for `din`.
- `din` in 8: byte to transmit.
- `ovf_clr` in 1: clears `overflow`.
- `tx` out 1: serial line, registered.
- `full` out 1: FIFO holds `FIFO_DEPTH` bytes.
- `busy` out 1: a frame is in progress or the FIFO is non-empty.
- `tx_done` out 1: one-`clk` pulse when a frame's last stop bit ends.
- `overflow` out 1: sticky; a write was dropped.

## Operation
- FIFO
  - Circular buffer with a `$clog2(FIFO_DEPTH)`-bit read pointer and write pointer; pointers wrap naturally.
  - Occupancy count is `$clog2(FIFO_DEPTH)+1` bits.
  - A write is accepted iff `wr_en && !full`, using the registered `full`.
  - `wr_en` while `full` drops the byte and sets `overflow`, even if a pop occurs in the same cycle.
  - A simultaneous write and pop leave the count unchanged.
- `overflow`: set has priority over `ovf_clr` in the same cycle.
- FSM states: IDLE, START, DATA, STOP. All transitions happen only on cycles with `baud_tick`=1.
- IDLE
  - `tx`=1.
  - On tick with FIFO non-empty: pop the head into the shift register, `tx`<=0, go to START.
- START: on tick, `tx`<=`shift[0]`, `bit_idx`<=0, go to DATA.
- DATA
  - On tick, if `bit_idx`==7: `tx`<=1, `stop_cnt`<=0, go to STOP.
  - Otherwise: `tx`<=`shift[bit_idx+1]`, `bit_idx`++.
- STOP
  - On tick, if `stop_cnt`==`STOP_BITS`-1: pulse `tx_done`.
    - If the FIFO is non-empty: pop, `tx`<=0, go to START. Back-to-back frames have no idle gap.
    - Otherwise go to IDLE.
  - On tick otherwise: `stop_cnt`++.
- `busy` = (state != IDLE) || (count != 0), registered or combinational from registers.
- `din` is captured at the write; later changes to `din` do not affect queued bytes.

## Timing
- Reset values:
  - `tx`=1, `busy`=0, `full`=0, `tx_done`=0, `overflow`=0.
  - FIFO empty, pointers 0, state IDLE.
- Reset mid-frame: `tx`=1 the cycle after `rst`. Queued and in-flight bytes are discarded.
- Every bit level on `tx` holds for exactly one tick-to-tick interval. `tx` changes the `clk` after a tick.
- Frame length is `10+(STOP_BITS-1)` bit periods.
- Write latency:
  - A byte written at cycle c into an empty FIFO in IDLE is visible at c+1.
  - A tick at c itself does not start it.
  - The first tick at ≥c+1 starts the frame, and `tx` falls one `clk` later.
- `full` asserts the cycle after the write that fills the FIFO, and deasserts the cycle after a pop.
- `tx_done` is high during the `clk` after the final stop-bit tick, for one cycle.
- `busy` falls one `clk` after the final stop tick when the FIFO is empty.
- `baud_tick` with no pending work in IDLE: no effect.

## Test plan
- Single byte: write 0xA5 in IDLE, ticks every 16 clk.
  - `tx` sequence 0,1,0,1,0,0,1,0,1,1, each level for 16 clk.
  - `tx_done` pulses once; `busy` then 0.
- Back-to-back: write 0x00 then 0xFF in consecutive cycles.
  - Second start bit immediately follows the first stop bit, with no idle period.
  - Two `tx_done` pulses 10 bit periods apart.
- Overflow (`FIFO_DEPTH`=4): write 0x11, 0x22, 0x33, 0x44, 0x55, 0x66 with no ticks.
  - 0x11 is popped only on a tick, so `full` asserts after the 4th write.
  - 0x55 and 0x66 are dropped and `overflow`=1.
  - Four correct frames follow once ticks run.
  - `ovf_clr` then clears `overflow`.
- `STOP_BITS`=2: send 0x3C.
  - Stop level lasts 2 bit periods; frame is 11 periods; `tx_done` comes after the 2nd stop period.
- Reset mid-frame: assert `rst` during DATA bit 3 with 2 bytes queued.
  - `tx`=1, `busy`=0, `full`=0 the next cycle.
  - No further frames; a fresh write of 0x5A transmits correctly.
- Loopback to the receiver (16x tick to the receiver, /16 tick to `uart_tx`): send bytes 0x00–0xFF.
  - Receiver `data_out` matches each byte and `rdy` asserts 256 times.

Source files
------------

// File: rtl/uart_tx.sv
// 8N1/8N2 UART transmitter fed by a small circular byte FIFO.
// Bit timing follows a 1x baud_tick; every tx level spans one tick-to-tick interval.
module uart_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic       wr_en,
    input  logic [7:0] din,
    input  logic       ovf_clr,
    output logic       tx,
    output logic       full,
    output logic       busy,
    output logic       tx_done,
    output logic       overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH = (PW+1)'(FIFO_DEPTH);
    localparam logic LAST_STOP = (STOP_BITS == 2);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic          stop_cnt_q, stop_cnt_d;
    logic          tx_q, tx_d;
    logic          tx_done_q, tx_done_d;
    logic          overflow_q, overflow_d;
    logic          push, pop, fifo_empty;

    assign fifo_empty = (count_q == '0);
    assign full       = (count_q == DEPTH);
    assign push       = wr_en && !full;
    assign busy       = (state_q != IDLE) || !fifo_empty;
    assign tx         = tx_q;
    assign tx_done    = tx_done_q;
    assign overflow   = overflow_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
        tx_done_d  = 1'b0;
        pop        = 1'b0;
        if (baud_tick) begin
            case (state_q)
                IDLE: begin
                    tx_d = 1'b1;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        tx_d    = 1'b0;
                        state_d = START;
                    end
                end
                START: begin
                    tx_d      = shift_q[0];
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end
                DATA: begin
                    if (bit_idx_q == 3'd7) begin
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
                        state_d    = STOP;
                    end else begin
                        tx_d      = shift_q[bit_idx_q + 3'd1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
                STOP: begin
                    if (stop_cnt_q == LAST_STOP) begin
                        tx_done_d = 1'b1;
                        // Chain straight into the next start bit when more data is queued.
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            shift_d = mem_q[rd_ptr_q];
                            tx_d    = 1'b0;
                            state_d = START;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A dropped write wins over a clear in the same cycle.
        if (wr_en && full)
            overflow_d = 1'b1;
        else if (ovf_clr)
            overflow_d = 1'b0;
        else
            overflow_d = overflow_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            tx_done_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            tx_done_q  <= tx_done_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: one 8N1 and one 8N2 instance, frame-level checks and a
// randomized loopback through a behavioural serial receiver.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_tick;
    logic       wr_en0, wr_en1, ovf_clr0, ovf_clr1;
    logic [7:0] din0, din1;
    logic       tx0, full0, busy0, tx_done0, overflow0;
    logic       tx1, full1, busy1, tx_done1, overflow1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int tick_period = 16;
    int tick_cnt = 0;
    bit tick_en = 1'b0;
    bit mon_en = 1'b0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int done_times[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx #(.FIFO_DEPTH(4), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .wr_en(wr_en0), .din(din0),
        .ovf_clr(ovf_clr0), .tx(tx0), .full(full0), .busy(busy0),
        .tx_done(tx_done0), .overflow(overflow0)
    );

    uart_tx #(.FIFO_DEPTH(4), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .wr_en(wr_en1), .din(din1),
        .ovf_clr(ovf_clr1), .tx(tx1), .full(full1), .busy(busy1),
        .tx_done(tx_done1), .overflow(overflow1)
    );

    // Free-running baud tick, one clk wide, every tick_period clocks.
    initial begin
        baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            if (tick_en) begin
                if (tick_cnt >= tick_period - 1) begin
                    baud_tick = 1'b1;
                    tick_cnt = 0;
                end else begin
                    baud_tick = 1'b0;
                    tick_cnt++;
                end
            end
        end
    end

    always @(negedge clk) if (tx_done0) done_times.push_back(cyc);

    // Serial receiver model: mid-bit sampling after a falling start edge.
    initial begin
        logic [7:0] b;
        logic       stop;
        forever begin
            @(negedge clk);
            if (mon_en && tx0 == 1'b0) begin
                repeat (tick_period / 2) @(negedge clk);
                checkOutput("rx start bit", tx0, 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (tick_period) @(negedge clk);
                    b[i] = tx0;
                end
                repeat (tick_period) @(negedge clk);
                stop = tx0;
                checkOutput("rx stop bit", stop, 1'b1);
                rx_q.push_back(b);
            end
        end
    end

    function automatic logic txOf(input bit sel);
        return sel ? tx1 : tx0;
    endfunction

    function automatic logic busyOf(input bit sel);
        return sel ? busy1 : busy0;
    endfunction

    function automatic logic doneOf(input bit sel);
        return sel ? tx_done1 : tx_done0;
    endfunction

    // Line levels per bit period, index 0 = start bit.
    function automatic logic [10:0] frameBits(input logic [7:0] data);
        logic [10:0] f;
        f = '0;
        for (int i = 0; i < 8; i++) f[i + 1] = data[i];
        f[9] = 1'b1;
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit sel, input logic [7:0] data);
        if (sel) begin wr_en1 = 1'b1; din1 = data; end
        else begin wr_en0 = 1'b1; din0 = data; end
        @(negedge clk);
        wr_en0 = 1'b0;
        wr_en1 = 1'b0;
        din0 = 8'($urandom);
        din1 = 8'($urandom);
    endtask

    task automatic waitFall(input bit sel, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 4 * tick_period + 8; i++) begin
            if (txOf(sel) == 1'b0) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checkOutput({name, " start seen"}, ok, 1'b1);
    endtask

    task automatic waitIdle(input bit sel, input int limit, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (busyOf(sel) == 1'b0) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checkOutput({name, " idle reached"}, ok, 1'b1);
    endtask

    task automatic checkFrame(input bit sel, input logic [10:0] exp, input int nbits, input string name);
        logic lvl;
        for (int k = 0; k < nbits; k++) begin
            lvl = exp[k];
            repeat (tick_period) begin
                if (txOf(sel) !== exp[k]) lvl = txOf(sel);
                @(negedge clk);
            end
            checkOutput($sformatf("%s period%0d", name, k), lvl, exp[k]);
        end
    endtask

    typedef struct {
        bit          sel;
        logic [7:0]  data;
        logic [10:0] frame;
        int          nbits;
    } vec_t;

    initial begin
        vec_t vecs[5];
        logic [7:0] vals[6];
        bit   bad;
        bit   ok;
        int   gap;

        vecs[0] = '{1'b0, 8'hA5, 11'h34A, 10};
        vecs[1] = '{1'b0, 8'h00, 11'h200, 10};
        vecs[2] = '{1'b0, 8'hFF, 11'h3FE, 10};
        vecs[3] = '{1'b1, 8'h3C, 11'h678, 11};
        vecs[4] = '{1'b1, 8'h81, 11'h702, 11};

        rst = 1'b1;
        wr_en0 = 1'b0; wr_en1 = 1'b0; din0 = '0; din1 = '0;
        ovf_clr0 = 1'b0; ovf_clr1 = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset tx", tx0, 1'b1);
        checkOutput("reset busy", busy0, 1'b0);
        checkOutput("reset full", full0, 1'b0);
        checkOutput("reset tx_done", tx_done0, 1'b0);
        checkOutput("reset overflow", overflow0, 1'b0);
        checkOutput("reset tx dut1", tx1, 1'b1);
        checkOutput("reset busy dut1", busy1, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // A tick in the write cycle must not start the frame; the next tick does.
        baud_tick = 1'b1;
        wr_en0 = 1'b1; din0 = 8'hC3;
        @(negedge clk);
        wr_en0 = 1'b0; baud_tick = 1'b0;
        checkOutput("latency same-cycle tick tx", tx0, 1'b1);
        checkOutput("latency busy after write", busy0, 1'b1);
        repeat (2) @(negedge clk);
        checkOutput("latency no tick tx", tx0, 1'b1);
        baud_tick = 1'b1;
        @(negedge clk);
        baud_tick = 1'b0;
        checkOutput("latency tx falls after tick", tx0, 1'b0);
        tick_cnt = 0; tick_en = 1'b1;
        waitIdle(1'b0, 12 * tick_period, "latency frame");

        for (int v = 0; v < 5; v++) begin
            applyStimulus(vecs[v].sel, vecs[v].data);
            waitFall(vecs[v].sel, $sformatf("vec%0d", v));
            checkFrame(vecs[v].sel, vecs[v].frame, vecs[v].nbits, $sformatf("vec%0d", v));
            checkOutput($sformatf("vec%0d tx_done", v), doneOf(vecs[v].sel), 1'b1);
            checkOutput($sformatf("vec%0d busy", v), busyOf(vecs[v].sel), 1'b0);
            @(negedge clk);
            checkOutput($sformatf("vec%0d tx_done width", v), doneOf(vecs[v].sel), 1'b0);
            repeat (5) @(negedge clk);
        end

        // Back-to-back frames from consecutive-cycle writes.
        done_times.delete();
        wr_en0 = 1'b1; din0 = 8'h00;
        @(negedge clk);
        din0 = 8'hFF;
        @(negedge clk);
        wr_en0 = 1'b0;
        waitFall(1'b0, "b2b");
        checkFrame(1'b0, frameBits(8'h00), 10, "b2b first");
        checkFrame(1'b0, frameBits(8'hFF), 10, "b2b second");
        @(negedge clk);
        checkOutput("b2b done count", done_times.size(), 2);
        gap = (done_times.size() >= 2) ? done_times[1] - done_times[0] : -1;
        checkOutput("b2b done spacing", gap, 10 * tick_period);
        waitIdle(1'b0, 4 * tick_period, "b2b");

        // Overflow: six writes with ticks stopped.
        tick_en = 1'b0; baud_tick = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 6; i++) vals[i] = 8'((i + 1) * 8'h11);
        for (int i = 0; i < 6; i++) begin
            wr_en0 = 1'b1; din0 = vals[i];
            @(negedge clk);
            if (i == 3) begin
                checkOutput("ovf full after 4th", full0, 1'b1);
                checkOutput("ovf clean after 4th", overflow0, 1'b0);
            end
        end
        wr_en0 = 1'b0;
        checkOutput("ovf flag", overflow0, 1'b1);
        checkOutput("ovf full held", full0, 1'b1);
        rx_q.delete();
        mon_en = 1'b1;
        tick_cnt = 0; tick_en = 1'b1;
        waitIdle(1'b0, 60 * tick_period, "ovf drain");
        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        checkOutput("ovf frames received", rx_q.size(), 4);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("ovf byte%0d", i), (i < rx_q.size()) ? rx_q[i] : 8'hxx, vals[i]);
        checkOutput("ovf sticky", overflow0, 1'b1);
        ovf_clr0 = 1'b1;
        @(negedge clk);
        ovf_clr0 = 1'b0;
        checkOutput("ovf cleared", overflow0, 1'b0);

        // Reset during data bit 3 with two bytes still queued.
        wr_en0 = 1'b1; din0 = 8'h12;
        @(negedge clk);
        din0 = 8'h34;
        @(negedge clk);
        din0 = 8'h56;
        @(negedge clk);
        wr_en0 = 1'b0;
        waitFall(1'b0, "rst mid");
        repeat (4 * tick_period + tick_period / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst mid tx", tx0, 1'b1);
        checkOutput("rst mid busy", busy0, 1'b0);
        checkOutput("rst mid full", full0, 1'b0);
        rst = 1'b0;
        bad = 1'b0;
        repeat (12 * tick_period) begin
            if (tx0 !== 1'b1) bad = 1'b1;
            @(negedge clk);
        end
        checkOutput("rst mid line stays idle", bad, 1'b0);
        applyStimulus(1'b0, 8'h5A);
        waitFall(1'b0, "post rst");
        checkFrame(1'b0, frameBits(8'h5A), 10, "post rst");
        waitIdle(1'b0, 4 * tick_period, "post rst");

        // Randomized loopback of every byte value at a faster bit rate.
        tick_en = 1'b0;
        @(negedge clk);
        tick_period = 8; tick_cnt = 0; tick_en = 1'b1;
        rx_q.delete(); exp_q.delete();
        mon_en = 1'b1;
        for (int b = 0; b < 256; b++) begin
            ok = 1'b0;
            for (int i = 0; i < 30 * tick_period; i++) begin
                if (!full0) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            if (!ok) begin
                checkOutput("loopback full timeout", ok, 1'b1);
                break;
            end
            applyStimulus(1'b0, 8'(b));
            exp_q.push_back(8'(b));
            gap = ($urandom_range(0, 9) == 0) ? $urandom_range(20, 120) : $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
        end
        waitIdle(1'b0, 8 * 11 * tick_period, "loopback");
        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        checkOutput("loopback count", rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            checkOutput($sformatf("loopback byte%0d", i), (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
        checkOutput("loopback no overflow", overflow0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
